// File: rtl/chacha_pkg.sv
// Shared types and constants for the iterative ChaCha20 block core.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;

    // Sub-step of one quarter-round: IDLE loads operands, S0..S7 are the ARX steps
    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7
    } ARXSTATE;

    // Which quarter-round of the double round is active (Q0-Q3 columns, Q4-Q7 diagonals)
    typedef enum logic [2:0] {
        Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    } QSTATE;

    localparam int ROUNDS_DEFAULT = 20;

    localparam int ROT_A = 16;
    localparam int ROT_B = 12;
    localparam int ROT_C = 8;
    localparam int ROT_D = 7;

    // Left rotation of a 32-bit word; n must be 1..31
    function automatic word_t rol(word_t x, int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Column of the operand taken from a given row for a quarter-round.
    // Column rounds use the quarter number as the column; diagonal rounds
    // shift one column right per row, wrapping around.
    function automatic logic [1:0] operandCol(QSTATE q, logic [1:0] row);
        logic [2:0] qv;
        qv = q;
        return qv[2] ? (qv[1:0] + row) : qv[1:0];
    endfunction

endpackage

// File: rtl/chacha_arx_step.sv
// One ARX step of the ChaCha quarter-round, selected by the current sub-step.
module chacha_arx_step
    import chacha_pkg::*;
(
    input  word_t   a_i,
    input  word_t   b_i,
    input  word_t   c_i,
    input  word_t   d_i,
    input  ARXSTATE step_i,
    output word_t   a_o,
    output word_t   b_o,
    output word_t   c_o,
    output word_t   d_o
);

    // Each step updates exactly one operand; the others pass through
    always_comb begin
        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        d_o = d_i;
        case (step_i)
            S0:      a_o = a_i + b_i;
            S1:      d_o = rol(d_i ^ a_i, ROT_A);
            S2:      c_o = c_i + d_i;
            S3:      b_o = rol(b_i ^ c_i, ROT_B);
            S4:      a_o = a_i + b_i;
            S5:      d_o = rol(d_i ^ a_i, ROT_C);
            S6:      c_o = c_i + d_i;
            S7:      b_o = rol(b_i ^ c_i, ROT_D);
            default: ;
        endcase
    end

endmodule

// File: rtl/chacha_perform_qround.sv
// Iterative ChaCha20 block core: one ARX step per clock, nine clocks per
// quarter-round, eight quarter-rounds per double round, then a final
// feed-forward addition of the original state.
module chacha_perform_qround
    import chacha_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setRounds,
    input  logic [3:0][3:0][31:0] chachamatrixIN,
    output logic [3:0][3:0][31:0] chachamatrixOUT,
    output logic                  blockready,
    output logic [3:0]            blocksproduced
);

    localparam logic [7:0] LAST_DOUBLE = 8'(ROUNDS / 2);

    ARXSTATE    step_q, step_d;
    QSTATE      quarter_q, quarter_d;
    logic [7:0] rounds_q, rounds_d;
    logic       armed_q, armed_d;

    word_t      a_q, b_q, c_q, d_q;
    word_t      a_d, b_d, c_d, d_d;
    word_t      aNext, bNext, cNext, dNext;

    matrix_t    working_q, working_d;
    matrix_t    original_q, original_d;
    matrix_t    out_q, out_d;
    logic       ready_q, ready_d;
    logic [3:0] count_q, count_d;

    logic       finishing;
    logic [1:0] colA, colB, colC, colD;

    assign colA = operandCol(quarter_q, 2'd0);
    assign colB = operandCol(quarter_q, 2'd1);
    assign colC = operandCol(quarter_q, 2'd2);
    assign colD = operandCol(quarter_q, 2'd3);

    // The finish step takes the place of a load step once all double rounds are done
    assign finishing = armed_q && (step_q == IDLE) && (rounds_q == LAST_DOUBLE);

    chacha_arx_step u_arx (
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .d_i    (d_q),
        .step_i (step_q),
        .a_o    (aNext),
        .b_o    (bNext),
        .c_o    (cNext),
        .d_o    (dNext)
    );

    // State register for the FSM, counters and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q     <= IDLE;
            quarter_q  <= Q0;
            rounds_q   <= '0;
            armed_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            working_q  <= '0;
            original_q <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            step_q     <= step_d;
            quarter_q  <= quarter_d;
            rounds_q   <= rounds_d;
            armed_q    <= armed_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            working_q  <= working_d;
            original_q <= original_d;
            out_q      <= out_d;
            ready_q    <= ready_d;
            count_q    <= count_d;
        end
    end

    // Next-state sequencing: step walks IDLE..S7, quarter advances after S7,
    // and the double-round count advances after the Q7 writeback
    always_comb begin
        step_d    = step_q;
        quarter_d = quarter_q;
        rounds_d  = rounds_q;
        armed_d   = armed_q;
        if (setRounds) begin
            step_d    = IDLE;
            quarter_d = Q0;
            rounds_d  = '0;
            armed_d   = 1'b1;
        end else if (armed_q) begin
            if (step_q == IDLE) begin
                if (finishing) begin
                    armed_d  = 1'b0;
                    rounds_d = '0;
                end else begin
                    step_d = S0;
                end
            end else if (step_q == S7) begin
                step_d    = IDLE;
                quarter_d = QSTATE'(quarter_q + 3'd1);
                if (quarter_q == Q7) begin
                    rounds_d = rounds_q + 8'd1;
                end
            end else begin
                step_d = ARXSTATE'(step_q + 4'd1);
            end
        end
    end

    // Datapath: capture on load, fetch operands in IDLE, run ARX steps,
    // write back on S7, and add the original state on the finish step
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        working_d  = working_q;
        original_d = original_q;
        out_d      = out_q;
        ready_d    = 1'b0;
        count_d    = count_q;
        if (setRounds) begin
            original_d = chachamatrixIN;
            working_d  = chachamatrixIN;
        end else if (armed_q) begin
            if (step_q == IDLE) begin
                if (finishing) begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            out_d[i][j] = working_q[i][j] + original_q[i][j];
                        end
                    end
                    ready_d = 1'b1;
                    count_d = count_q + 4'd1;
                end else begin
                    a_d = working_q[0][colA];
                    b_d = working_q[1][colB];
                    c_d = working_q[2][colC];
                    d_d = working_q[3][colD];
                end
            end else begin
                a_d = aNext;
                b_d = bNext;
                c_d = cNext;
                d_d = dNext;
                if (step_q == S7) begin
                    working_d[0][colA] = aNext;
                    working_d[1][colB] = bNext;
                    working_d[2][colC] = cNext;
                    working_d[3][colD] = dNext;
                end
            end
        end
    end

    assign chachamatrixOUT = out_q;
    assign blockready      = ready_q;
    assign blocksproduced  = count_q;

endmodule

// File: tb/tb_chacha_perform_qround.sv
// Self-checking bench for the iterative ChaCha20 block core.
module tb_chacha_perform_qround;

    localparam int ROUNDS      = 20;
    localparam int BLOCK_EDGES = (ROUNDS / 2) * 72 + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  setRounds;
    logic [3:0][3:0][31:0] matIn;
    logic [3:0][3:0][31:0] matOut;
    logic                  blockready;
    logic [3:0]            blocksproduced;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEnable = 1'b0;

    always #5 clk = ~clk;

    chacha_perform_qround dut (
        .clk             (clk),
        .rst             (rst),
        .setRounds       (setRounds),
        .chachamatrixIN  (matIn),
        .chachamatrixOUT (matOut),
        .blockready      (blockready),
        .blocksproduced  (blocksproduced)
    );

    // Operand columns for a, b, c, d of each quarter-round
    int qCols [8][4] = '{
        '{0, 0, 0, 0}, '{1, 1, 1, 1}, '{2, 2, 2, 2}, '{3, 3, 3, 3},
        '{0, 1, 2, 3}, '{1, 2, 3, 0}, '{2, 3, 0, 1}, '{3, 0, 1, 2}
    };

    logic [31:0] rfcInW [16] = '{
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000
    };
    logic [31:0] rfcOutW [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
    };

    // Reference model state
    logic [3:0][3:0][31:0] workM  = '0;
    logic [3:0][3:0][31:0] origM  = '0;
    logic [3:0][3:0][31:0] expOut = '0;
    logic                  expReady = 1'b0;
    logic [3:0]            expCount = '0;
    logic [31:0]           expA = '0, expB = '0, expC = '0, expD = '0;
    bit                    abcdPending = 1'b0;
    bit                    armedM = 1'b0;
    int                    edges = 0;

    function automatic logic [31:0] rotl(logic [31:0] x, int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Plain ChaCha quarter-round applied to the model matrix
    function automatic void applyQuarter(int q);
        logic [31:0] a, b, c, d;
        a = workM[0][qCols[q][0]];
        b = workM[1][qCols[q][1]];
        c = workM[2][qCols[q][2]];
        d = workM[3][qCols[q][3]];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        workM[0][qCols[q][0]] = a;
        workM[1][qCols[q][1]] = b;
        workM[2][qCols[q][2]] = c;
        workM[3][qCols[q][3]] = d;
        expA = a; expB = b; expC = c; expD = d;
    endfunction

    task automatic checkVal(string name, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][3:0][31:0] randMat();
        logic [3:0][3:0][31:0] m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = $urandom;
        return m;
    endfunction

    // Model: counts edges since start; a quarter completes every ninth edge,
    // the block completes on the edge after the last double round
    always @(posedge clk) begin
        abcdPending = 1'b0;
        expReady    = 1'b0;
        if (rst) begin
            armedM   = 1'b0;
            edges    = 0;
            expOut   = '0;
            expCount = '0;
            workM    = '0;
            origM    = '0;
        end else if (setRounds) begin
            origM  = matIn;
            workM  = matIn;
            armedM = 1'b1;
            edges  = 0;
        end else if (armedM) begin
            edges++;
            if (edges == BLOCK_EDGES) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        expOut[i][j] = workM[i][j] + origM[i][j];
                expReady = 1'b1;
                expCount = expCount + 4'd1;
                armedM   = 1'b0;
                edges    = 0;
            end else if (edges % 9 == 0) begin
                applyQuarter(((edges / 9) - 1) % 8);
                abcdPending = 1'b1;
            end
        end
    end

    // Compare DUT outputs against the model on every cycle
    always @(negedge clk) begin
        if (checkEnable) begin
            checkVal("blockready", 512'(blockready), 512'(expReady));
            checkVal("blocksproduced", 512'(blocksproduced), 512'(expCount));
            checkVal("chachamatrixOUT", matOut, expOut);
            if (abcdPending) begin
                checkVal("quarter a", 512'(dut.a_q), 512'(expA));
                checkVal("quarter b", 512'(dut.b_q), 512'(expB));
                checkVal("quarter c", 512'(dut.c_q), 512'(expC));
                checkVal("quarter d", 512'(dut.d_q), 512'(expD));
            end
        end
    end

    task automatic applyStimulus(input logic [3:0][3:0][31:0] m);
        matIn     = m;
        setRounds = 1'b1;
        @(negedge clk);
        setRounds = 1'b0;
    endtask

    task automatic checkOutput(string name, int expEdges);
        int n;
        n = 0;
        while (blockready !== 1'b1 && n < BLOCK_EDGES + 20) begin
            @(negedge clk);
            n++;
        end
        checkVal({name, " done"}, 512'(blockready), 512'(1));
        checkVal({name, " latency"}, 512'(n), 512'(expEdges));
    endtask

    logic [3:0][3:0][31:0] m;

    initial begin
        rst       = 1'b1;
        setRounds = 1'b0;
        matIn     = '0;
        repeat (2) @(negedge clk);
        checkEnable = 1'b1;
        checkVal("reset out", matOut, 512'(0));
        checkVal("reset ready", 512'(blockready), 512'(0));
        checkVal("reset count", 512'(blocksproduced), 512'(0));
        checkVal("reset a", 512'(dut.a_q), 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // RFC 7539 full block
        for (int i = 0; i < 16; i++) m[i / 4][i % 4] = rfcInW[i];
        applyStimulus(m);
        checkOutput("rfc", BLOCK_EDGES);
        for (int i = 0; i < 16; i++) m[i / 4][i % 4] = rfcOutW[i];
        checkVal("rfc word00", 512'(matOut[0][0]), 512'(32'he4e7f110));
        checkVal("rfc word01", 512'(matOut[0][1]), 512'(32'h15593bd1));
        checkVal("rfc block", matOut, m);
        checkVal("rfc count", 512'(blocksproduced), 512'(1));
        @(negedge clk);
        checkVal("rfc ready pulse", 512'(blockready), 512'(0));

        // RFC 7539 quarter-round vector in column 0
        m = randMat();
        m[0][0] = 32'h11111111;
        m[1][0] = 32'h01020304;
        m[2][0] = 32'h9b8d6f43;
        m[3][0] = 32'h01234567;
        applyStimulus(m);
        repeat (9) @(negedge clk);
        checkVal("qr a", 512'(dut.a_q), 512'(32'hea2a92f4));
        checkVal("qr b", 512'(dut.b_q), 512'(32'hcb1cf8ce));
        checkVal("qr c", 512'(dut.c_q), 512'(32'h4581472e));
        checkVal("qr d", 512'(dut.d_q), 512'(32'h5881c4bb));
        checkOutput("qr block", BLOCK_EDGES - 9);

        // All-zero key/counter/nonce with the expand constants
        m = '0;
        for (int j = 0; j < 4; j++) m[0][j] = rfcInW[j];
        applyStimulus(m);
        checkOutput("zero key", BLOCK_EDGES);
        checkVal("zero key word0", 512'(matOut[0][0]), 512'(32'hade0b876));

        // Fully zero matrix stays zero
        applyStimulus('0);
        checkOutput("all zero", BLOCK_EDGES);
        checkVal("all zero out", matOut, 512'(0));

        // Random blocks through the counter wrap (blocks 5..16)
        for (int k = 0; k < 12; k++) begin
            applyStimulus(randMat());
            checkOutput("random", BLOCK_EDGES);
        end
        checkVal("count wrap", 512'(blocksproduced), 512'(0));

        // Abort at edge 300 with a reload
        applyStimulus(randMat());
        repeat (299) @(negedge clk);
        applyStimulus(randMat());
        checkOutput("after abort", BLOCK_EDGES);

        // Held load keeps reloading; input changes after release are ignored
        setRounds = 1'b1;
        repeat (20) begin
            matIn = randMat();
            @(negedge clk);
        end
        setRounds = 1'b0;
        matIn     = randMat();
        checkOutput("held load", BLOCK_EDGES);

        // Reset mid-block: everything clears and the core stays idle
        applyStimulus(randMat());
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (BLOCK_EDGES + 50) @(negedge clk);
        checkVal("midreset out", matOut, 512'(0));
        checkVal("midreset count", 512'(blocksproduced), 512'(0));
        checkVal("midreset ready", 512'(blockready), 512'(0));

        checkEnable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chacha_perform_qround.md
Name: chacha_perform_qround

Overview:
- Iterative ChaCha20 block-function core.
- Takes a 4x4 matrix of 32-bit words and runs 20 rounds (10 double rounds). Each double round is 4 column quarter-rounds Q0–Q3, then 4 diagonal quarter-rounds Q4–Q7.
- Adds the original input state to the result and presents the keystream block.
- Sits between the state-builder (key/nonce/counter) and the Poly1305/XOR stages of the AEAD.

Parameters:
- ROUNDS, 20, total ChaCha rounds; must be even. Double rounds = ROUNDS/2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- setRounds  in  1  load strobe: while high, the input matrix is captured and the core is held idle
- chachamatrixIN  in  [3:0][3:0] x 32  input state; index [row][col]; row0 holds the constants
- chachamatrixOUT  out  [3:0][3:0] x 32  final block = working state + input state, per word mod 2^32
- blockready  out  1  one-cycle pulse when chachamatrixOUT updates
- blocksproduced  out  4  count of completed blocks; wraps 15->0

Behaviour:
- Reset, sampled at a clock edge with rst=1:
  - chachamatrixOUT, blockready, blocksproduced, working state, a/b/c/d all go to 0.
  - FSM goes to IDLE with CurrQ=Q0; the armed flag is cleared.
  - rst has priority over everything, including mid-operation.
- Load:
  - Any edge with setRounds=1 copies chachamatrixIN into the original-state register and the working state.
  - It also sets armed=1 and forces IDLE/Q0; a block in progress is aborted.
- Start: the first edge with setRounds=0 and armed=1 begins the block (edge 1). armed is cleared at completion.
- Quarter schedule, 9 edges per quarter:
  - IDLE/load step: a,b,c,d are loaded from the working state according to CurrQ.
  - Then S0..S7 run, one ARX step per edge:
    - S0: a=a+b
    - S1: d=rol16(d^a)
    - S2: c=c+d
    - S3: b=rol12(b^c)
    - S4: a=a+b
    - S5: d=rol8(d^a)
    - S6: c=c+d
    - S7: b=rol7(b^c); a,b,c,d are written back to their source cells
  - After S7: CurrQ advances Q0->…->Q7->Q0 and Currstep returns to IDLE.
  - All additions are mod 2^32; rotations are left rotations.
- Quarter operand selection, each as [row][col] for a, b, c, d:
  - Q0: [0][0], [1][0], [2][0], [3][0]
  - Q1: column 1, same row pattern
  - Q2: column 2, same row pattern
  - Q3: column 3, same row pattern
  - Q4: [0][0], [1][1], [2][2], [3][3]
  - Q5: [0][1], [1][2], [2][3], [3][0]
  - Q6: [0][2], [1][3], [2][0], [3][1]
  - Q7: [0][3], [1][0], [2][1], [3][2]
  - Diagonal rounds read the state after Q0–Q3 writeback of the same double round.
- Round counter: increments after each Q7 writeback. After ROUNDS/2 double rounds (edges 1..720 at default), edge 721 performs the final step:
  - chachamatrixOUT[i][j] = working[i][j] + original[i][j].
  - blockready=1 and blocksproduced=blocksproduced+1.
- blockready returns to 0 on the next edge. chachamatrixOUT holds its value until the next completion or reset.
- After completion the core idles; a new block requires a new setRounds pulse.
- setRounds=1 held continuously keeps reloading; no ARX step executes.
- chachamatrixIN may change after load without effect.

Decomposition:
- Package chacha_pkg holds:
  - word_t (logic [31:0])
  - ARXSTATE enum {IDLE,S0..S7}
  - QSTATE enum {Q0..Q7}
  - ROUNDS default
  - rotate amounts 16/12/8/7
- One sub-module, chacha_arx_step: combinational; inputs a,b,c,d and step; outputs next a,b,c,d.
- The top module holds the FSM, counters, matrices and the operand mux.

Test Plan:
- Quarter-round check:
  - Stimulus: load a matrix with column0 = 11111111, 01020304, 9b8d6f43, 01234567; probe a/b/c/d after Q0's S7 (edge 9).
  - Required: a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb (RFC 7539 2.1.1).
- Full block:
  - Stimulus: RFC 7539 2.3.2 state (key 00..1f, counter 1, nonce 000000090000004a00000000).
  - Required: blockready pulses exactly one cycle after edge 721; chachamatrixOUT[0][0]=e4e7f110, [0][1]=15593bd1, matching all 16 RFC words; blocksproduced=1.
- Per-step scoreboard:
  - Stimulus: random matrix, compared after every edge.
  - Required: a–d match the S0..S7 formulas; Q4–Q7 operands equal the post-Q3 diagonals.
- Counter wrap: 16 back-to-back blocks -> blocksproduced steps 1..15, then 0.
- Abort/reset:
  - setRounds=1 at edge 300 -> no blockready, and a fresh run completes 721 edges after release.
  - rst=1 mid-block -> all outputs 0 and the core stays idle without setRounds.
- All-zero input: load zeros -> output equals the RFC all-zero-key block with word0=ade0b876 when row0 = expand constants; with a fully zero matrix, the output stays all 0.
